// File: rtl/secuenciador_coeficientes_iir_pkg.sv
// Shared definitions for the IIR coefficient sequencer: state encoding,
// band codes and datapath sizing.
package filtro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        MAC   = 2'd2,
        STORE = 2'd3
    } estado_t;

    localparam logic [1:0] BANDA_OFF   = 2'b00;
    localparam logic [1:0] BANDA_BAJO  = 2'b01;
    localparam logic [1:0] BANDA_MEDIO = 2'b10;
    localparam logic [1:0] BANDA_ALTO  = 2'b11;

    localparam int NUM_TAPS_DEF = 5;
    localparam int COEF_WIDTH   = 22;

endpackage

// File: rtl/secuenciador_coeficientes_iir_sincronizador_sel.sv
// Multi-flop synchronizer for the asynchronous 2-bit band select.
module sincronizador_sel #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] d,
    output logic [1:0] q
);

    logic [1:0] etapas [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                etapas[i] <= 2'b00;
            end
        end else begin
            etapas[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                etapas[i] <= etapas[i-1];
            end
        end
    end

    assign q = etapas[SYNC_STAGES-1];

endmodule

// File: rtl/secuenciador_coeficientes_iir.sv
// Sequencer for the shared MAC datapath of the recursive filter: walks the
// coefficient slots per sample and applies band changes only at sample boundaries.
//
// state | meaning
// IDLE  | waiting for a sample, listo=1
// FLUSH | band changed, clear x/y history (1 cycle)
// MAC   | one tap per cycle, indice 0..NUM_TAPS-1
// STORE | shift delay lines, publish y[n] (1 cycle)
module secuenciador_coeficientes_iir
    import filtro_pkg::*;
#(
    parameter int NUM_TAPS    = NUM_TAPS_DEF,
    parameter int IDX_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel_in,
    input  logic             muestra_valida,
    output logic             listo,
    output logic [1:0]       sel_coef,
    output logic [IDX_W-1:0] indice_coef,
    output logic             acc_clr,
    output logic             mac_en,
    output logic             borrar_historia,
    output logic             desplazar,
    output logic             salida_valida,
    output logic             sobrecarga
);

    localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(NUM_TAPS - 1);

    estado_t    estado;
    logic [1:0] sel_sync;

    sincronizador_sel #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sincronizador_sel (
        .clk   (clk),
        .reset (reset),
        .d     (sel_in),
        .q     (sel_sync)
    );

    // All control outputs are set on the edge that enters the state they belong to,
    // so each one is a plain flop and lines up with the state it describes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado          <= IDLE;
            listo           <= 1'b1;
            sel_coef        <= BANDA_OFF;
            indice_coef     <= '0;
            acc_clr         <= 1'b0;
            mac_en          <= 1'b0;
            borrar_historia <= 1'b0;
            desplazar       <= 1'b0;
            salida_valida   <= 1'b0;
            sobrecarga      <= 1'b0;
        end else begin
            acc_clr         <= 1'b0;
            mac_en          <= 1'b0;
            borrar_historia <= 1'b0;
            desplazar       <= 1'b0;
            salida_valida   <= 1'b0;

            if (muestra_valida && !listo) begin
                sobrecarga <= 1'b1;
            end

            case (estado)
                IDLE: begin
                    if (muestra_valida) begin
                        listo <= 1'b0;
                        if (sel_sync != sel_coef) begin
                            sel_coef        <= sel_sync;
                            borrar_historia <= 1'b1;
                            estado          <= FLUSH;
                        end else begin
                            indice_coef <= '0;
                            mac_en      <= 1'b1;
                            acc_clr     <= 1'b1;
                            estado      <= MAC;
                        end
                    end
                end
                FLUSH: begin
                    indice_coef <= '0;
                    mac_en      <= 1'b1;
                    acc_clr     <= 1'b1;
                    estado      <= MAC;
                end
                MAC: begin
                    if (indice_coef == ULTIMO) begin
                        indice_coef   <= '0;
                        desplazar     <= 1'b1;
                        salida_valida <= 1'b1;
                        estado        <= STORE;
                    end else begin
                        indice_coef <= indice_coef + 1'b1;
                        mac_en      <= 1'b1;
                    end
                end
                STORE: begin
                    listo  <= 1'b1;
                    estado <= IDLE;
                end
                default: begin
                    listo  <= 1'b1;
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/secuenciador_coeficientes_iir.md
Name: secuenciador_coeficientes_iir

Overview:
Controls the shared multiply-accumulate datapath of the recursive filter.
- On each accepted input sample, steps through the NUM_TAPS coefficient slots (b0, b1, b2, a1, a2).
- Drives the coefficient-mux select and tap index, the accumulator controls, and the delay-line shift.
- Samples the user band selection (bajo/medio/alto) and applies it only at sample boundaries. When the band changes, it flushes the filter history first.

Parameters:
NUM_TAPS, 5, number of coefficient slots processed per sample (2..7)
IDX_W, 3, width of tap index; must satisfy 2^IDX_W >= NUM_TAPS
SYNC_STAGES, 2, flip-flop stages on the asynchronous sel_in input (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset; only this clock domain is used
sel_in  input  2  band select from switches, asynchronous: 00 off, 01 bajo, 10 medio, 11 alto
muestra_valida  input  1  new input sample available; qualified by listo
listo  output  1  controller idle, sample will be accepted this cycle
sel_coef  output  2  select to all coefficient muxes; stable during a sample
indice_coef  output  IDX_W  current tap slot, 0..NUM_TAPS-1
acc_clr  output  1  accumulator loads product instead of adding (first tap)
mac_en  output  1  multiply-accumulate enable
borrar_historia  output  1  clear x/y delay-line registers
desplazar  output  1  shift delay lines, register accumulator as y[n]
salida_valida  output  1  one-cycle pulse, y[n] valid at filter output next cycle
sobrecarga  output  1  sticky: a sample arrived while busy

Behaviour:
- Reset (reset=0 at a clk edge):
  - All outputs are 0 except listo=1.
  - sel_coef=00, state IDLE, synchronizer flops 00, sobrecarga=0.
  - Reset mid-sequence aborts immediately; no further mac_en or desplazar pulses occur.
- sel_in passes through SYNC_STAGES flops, giving sel_sync. sel_coef updates only on an accept.
- States:
  - IDLE: listo=1. On muestra_valida=1, capture sel_sync.
    - If sel_sync != sel_coef, set sel_coef<=sel_sync and go to FLUSH.
    - Otherwise go to MAC with indice_coef<=0.
  - FLUSH, 1 cycle: borrar_historia=1, listo=0. Next state is MAC with indice 0.
  - MAC, NUM_TAPS cycles: mac_en=1, indice_coef counts 0..NUM_TAPS-1, acc_clr=1 only when indice=0. After indice=NUM_TAPS-1, go to STORE.
  - STORE, 1 cycle: desplazar=1, salida_valida=1, indice_coef<=0. Next state is IDLE.
- Latency, counting the accept edge as cycle 0:
  - No band change: first mac_en in cycle 1, salida_valida in cycle NUM_TAPS+1 (6 by default).
  - With band change: add 1 cycle.
  - Throughput: one sample per NUM_TAPS+2 cycles, or +3 with a band change.
- Back-to-back samples: muestra_valida held high is accepted again in the first IDLE cycle after STORE. There are no lost cycles beyond IDLE.
- muestra_valida=1 while listo=0: the sample is ignored and sobrecarga<=1. sobrecarga clears only on reset.
- sel_in changing during MAC/FLUSH/STORE has no effect on sel_coef until the next accept.
- sel_in=00 is a legal band: all coefficients are zero, and the sequence runs normally.
- indice_coef, acc_clr, mac_en, borrar_historia, desplazar and salida_valida are registered outputs. acc_clr, mac_en and desplazar are mutually exclusive with borrar_historia.

Decomposition:
- Shared package filtro_pkg holds:
  - the state encoding (IDLE, FLUSH, MAC, STORE);
  - band constants BANDA_OFF=2'b00, BANDA_BAJO=2'b01, BANDA_MEDIO=2'b10, BANDA_ALTO=2'b11;
  - NUM_TAPS default and COEF_WIDTH=22.
- One natural sub-module: sincronizador_sel, a parameterised SYNC_STAGES flop chain for the 2-bit select.
- The FSM and tap counter stay in the top module.

Test Plan:
1. reset=0 for 3 cycles, then release -> listo=1, sel_coef=00, all pulses 0, sobrecarga=0.
2. sel_in=01 held >=3 cycles, then one muestra_valida pulse -> borrar_historia in cycle 1; mac_en cycles 2..6 with indice 0,1,2,3,4; acc_clr only in cycle 2; desplazar and salida_valida in cycle 7; sel_coef=01.
3. Second sample with sel_in still 01 -> no borrar_historia; salida_valida exactly 6 cycles after accept.
4. sel_in toggled 01->11 during MAC -> sel_coef stays 01 through STORE; the next sample causes FLUSH, then sel_coef=11.
5. muestra_valida held high for 20 cycles -> accepts every 7th cycle; sobrecarga=1 after the first busy-cycle assertion and stays 1.
6. reset=0 asserted at indice=2 -> next cycle listo=1, mac_en=0, sel_coef=00; no salida_valida for the aborted sample.
